dafx_mc_responder: RTL and testbench

AXI4 memory-controller responder; the slave end of the DAFX core's mc_* master port.

---
 rtl/dafx_mc_responder_if.sv | 62 ++++++
 rtl/dafx_mc_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dafx_mc_responder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dafx_mc_responder_if.sv
// AXI4 memory-controller bus between the DAFX core (master) and a responder (slave).
// Signal names match the core's mc_* port so the bundle reads like the core's netlist.
interface dafx_mc_responder_if #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    // write address
    logic [ID_W-1:0]     mc_awid;
    logic [ADDR_W-1:0]   mc_awaddr;
    logic [7:0]          mc_awlen;
    logic                mc_awvalid;
    logic                mc_awready;
    // write data
    logic [DATA_W-1:0]   mc_wdata;
    logic [DATA_W/8-1:0] mc_wstrb;
    logic                mc_wlast;
    logic                mc_wvalid;
    logic                mc_wready;
    // write response
    logic [ID_W-1:0]     mc_bid;
    logic [1:0]          mc_bresp;
    logic                mc_bvalid;
    logic                mc_bready;
    // read address
    logic [ID_W-1:0]     mc_arid;
    logic [ADDR_W-1:0]   mc_araddr;
    logic [7:0]          mc_arlen;
    logic                mc_arvalid;
    logic                mc_arready;
    // read data
    logic [ID_W-1:0]     mc_rid;
    logic [DATA_W-1:0]   mc_rdata;
    logic [1:0]          mc_rresp;
    logic                mc_rlast;
    logic                mc_rvalid;
    logic                mc_rready;

    modport master (
        output mc_awid, mc_awaddr, mc_awlen, mc_awvalid,
        output mc_wdata, mc_wstrb, mc_wlast, mc_wvalid,
        output mc_bready,
        output mc_arid, mc_araddr, mc_arlen, mc_arvalid,
        output mc_rready,
        input  mc_awready, mc_wready,
        input  mc_bid, mc_bresp, mc_bvalid,
        input  mc_arready,
        input  mc_rid, mc_rdata, mc_rresp, mc_rlast, mc_rvalid
    );

    modport slave (
        input  mc_awid, mc_awaddr, mc_awlen, mc_awvalid,
        input  mc_wdata, mc_wstrb, mc_wlast, mc_wvalid,
        input  mc_bready,
        input  mc_arid, mc_araddr, mc_arlen, mc_arvalid,
        input  mc_rready,
        output mc_awready, mc_wready,
        output mc_bid, mc_bresp, mc_bvalid,
        output mc_arready,
        output mc_rid, mc_rdata, mc_rresp, mc_rlast, mc_rvalid
    );
endinterface

// File: rtl/dafx_mc_responder.sv
// AXI4 memory-controller responder: slave end of the DAFX core's mc_* port.
// Register-array backed, INCR bursts only, one transaction at a time, round-robin
// between write and read when both request together.
// Optional build macro DAFX_MC_RESPONDER_THROTTLE_EN: one beat every two cycles
// (wready / rvalid dropped for a cycle after every beat) to mimic slow DRAM.
module dafx_mc_responder #(
    parameter int MC_ID_WIDTH_P   = 6,
    parameter int MC_ADDR_WIDTH_P = 32,
    parameter int MC_DATA_WIDTH_P = 128,
    parameter int MC_DEPTH_P      = 1024
) (
    input logic              clk,
    input logic              rst_n,
    dafx_mc_responder_if.slave mc
);
    localparam int STRB_W = MC_DATA_WIDTH_P / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    // one extra bit so an index past the top of the address space never wraps into range
    localparam int IW     = MC_ADDR_WIDTH_P + 1;
    localparam int DW     = $clog2(MC_DEPTH_P);
    localparam logic [IW-1:0] DEPTH_IDX = IW'(MC_DEPTH_P);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef DAFX_MC_RESPONDER_THROTTLE_EN
    localparam bit THROTTLE = 1'b1;
`else
    localparam bit THROTTLE = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WRESP, ST_READ} state_t;

    function automatic logic [IW-1:0] idx_of(input logic [MC_ADDR_WIDTH_P-1:0] addr);
        return {1'b0, addr} >> SHIFT;
    endfunction

    state_t                     state_q;
    logic                       prefer_read_q;
    logic                       awready_q, wready_q, arready_q;
    logic                       bvalid_q, rvalid_q, rlast_q, rd_ok_q, err_q;
    logic [1:0]                 bresp_q, rresp_q;
    logic [MC_ID_WIDTH_P-1:0]   bid_q, rid_q;
    logic [IW-1:0]              idx_q;
    logic [7:0]                 len_q, beat_q;

    logic                       aw_hs, ar_hs, w_hs, r_hs;
    logic                       w_in_range, w_final, wr_en, err_d;
    logic                       rd_en, rd_in_range;
    logic [IW-1:0]              rd_idx;
    logic [MC_DATA_WIDTH_P-1:0] mem_rd;

    assign aw_hs      = awready_q && mc.mc_awvalid;
    assign ar_hs      = arready_q && mc.mc_arvalid;
    assign w_hs       = wready_q && mc.mc_wvalid;
    assign r_hs       = rvalid_q && mc.mc_rready;
    assign w_in_range = idx_q < DEPTH_IDX;
    assign w_final    = beat_q == len_q;
    assign wr_en      = w_hs && w_in_range;
    // wlast must coincide exactly with the counted final beat
    assign err_d      = err_q || !w_in_range || (mc.mc_wlast != w_final);

    // Read port address: first beat straight from araddr so data is ready one cycle after AR
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = idx_q + IW'(1);
        if (ar_hs) begin
            rd_en  = 1'b1;
            rd_idx = idx_of(mc.mc_araddr);
        end else if (state_q == ST_READ) begin
            if (THROTTLE) rd_en = !rvalid_q;
            else          rd_en = r_hs && !rlast_q;
        end
    end
    assign rd_in_range = rd_idx < DEPTH_IDX;

    // Storage split into byte lanes so each strobe bit gates its own RAM
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] lane_mem [MC_DEPTH_P];
            logic [7:0] lane_rd_q;
            // Lane write on strobe, registered lane read when the read port advances
            always_ff @(posedge clk) begin
                if (wr_en && mc.mc_wstrb[gi]) lane_mem[idx_q[DW-1:0]] <= mc.mc_wdata[gi*8 +: 8];
                if (rd_en) lane_rd_q <= lane_mem[rd_idx[DW-1:0]];
            end
            assign mem_rd[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

    // Transaction FSM with registered handshake/response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            prefer_read_q <= 1'b0;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            arready_q     <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            bid_q         <= '0;
            rvalid_q      <= 1'b0;
            rlast_q       <= 1'b0;
            rresp_q       <= RESP_OKAY;
            rid_q         <= '0;
            rd_ok_q       <= 1'b0;
            err_q         <= 1'b0;
            idx_q         <= '0;
            len_q         <= '0;
            beat_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (awready_q) begin
                        awready_q <= 1'b0;
                        if (aw_hs) begin
                            state_q       <= ST_WRITE;
                            bid_q         <= mc.mc_awid;
                            len_q         <= mc.mc_awlen;
                            idx_q         <= idx_of(mc.mc_awaddr);
                            beat_q        <= '0;
                            err_q         <= 1'b0;
                            wready_q      <= 1'b1;
                            prefer_read_q <= 1'b1;
                        end
                    end else if (arready_q) begin
                        arready_q <= 1'b0;
                        if (ar_hs) begin
                            state_q       <= ST_READ;
                            rid_q         <= mc.mc_arid;
                            len_q         <= mc.mc_arlen;
                            idx_q         <= rd_idx;
                            beat_q        <= '0;
                            rvalid_q      <= 1'b1;
                            rlast_q       <= (mc.mc_arlen == 8'd0);
                            rd_ok_q       <= rd_in_range;
                            rresp_q       <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                            prefer_read_q <= 1'b0;
                        end
                    end else if (mc.mc_awvalid && (!mc.mc_arvalid || !prefer_read_q)) begin
                        awready_q <= 1'b1;
                    end else if (mc.mc_arvalid) begin
                        arready_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_hs) begin
                        idx_q  <= idx_q + IW'(1);
                        beat_q <= beat_q + 8'd1;
                        if (w_final) begin
                            wready_q <= 1'b0;
                            state_q  <= ST_WRESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= err_d ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            err_q <= err_d;
                            if (THROTTLE) wready_q <= 1'b0;
                        end
                    end else if (!wready_q) begin
                        wready_q <= 1'b1;
                    end
                end
                ST_WRESP: begin
                    if (mc.mc_bready) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= RESP_OKAY;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (rd_en) begin
                        idx_q    <= rd_idx;
                        beat_q   <= beat_q + 8'd1;
                        rlast_q  <= (beat_q + 8'd1 == len_q);
                        rd_ok_q  <= rd_in_range;
                        rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q <= 1'b1;
                    end else if (r_hs) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            rlast_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mc.mc_awready = awready_q;
    assign mc.mc_wready  = wready_q;
    assign mc.mc_arready = arready_q;
    assign mc.mc_bid     = bid_q;
    assign mc.mc_bresp   = bresp_q;
    assign mc.mc_bvalid  = bvalid_q;
    assign mc.mc_rid     = rid_q;
    // out-of-range beats and the reset state present zero data
    assign mc.mc_rdata   = rd_ok_q ? mem_rd : '0;
    assign mc.mc_rresp   = rresp_q;
    assign mc.mc_rlast   = rlast_q;
    assign mc.mc_rvalid  = rvalid_q;
endmodule

// File: tb/tb_dafx_mc_responder.sv
// Bench for dafx_mc_responder: directed cases plus random bursts, checked by a
// scoreboard fed from a word-array memory model.
module tb_dafx_mc_responder;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dafx_mc_responder_if #(.ID_W(6), .ADDR_W(32), .DATA_W(128)) mc();

    dafx_mc_responder #(
        .MC_ID_WIDTH_P(6), .MC_ADDR_WIDTH_P(32), .MC_DATA_WIDTH_P(128), .MC_DEPTH_P(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mc(mc)
    );

    typedef struct { logic [5:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [5:0] id; logic [127:0] data; logic [1:0] resp; logic last; bit chk; } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    int n_checks = 0;
    int n_errors = 0;
    int b_seen = 0;
    int r_seen = 0;
    bit last_wr = 1'b0;

    logic [127:0] mdl [DEPTH];
    bit           known [DEPTH];
    logic [127:0] wdat [256];
    logic [15:0]  wstb [256];
    logic         wlst [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired, got no handshake, expected one", name);
    endtask

    // Scoreboard monitor: samples on the falling edge, handshake completes at the next rising edge
    initial begin : monitor
        logic         hold_p;
        logic [5:0]   h_id;
        logic [127:0] h_data;
        logic [1:0]   h_resp;
        logic         h_last;
        b_exp_t       be;
        r_exp_t       re;
        hold_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_p = 1'b0;
            end else begin
                if (hold_p && mc.mc_rvalid) begin
                    chk("r_hold_data", mc.mc_rdata, h_data);
                    chk("r_hold_last", 128'(mc.mc_rlast), 128'(h_last));
                    chk("r_hold_id_resp", 128'({mc.mc_rid, mc.mc_rresp}), 128'({h_id, h_resp}));
                end
                hold_p = mc.mc_rvalid && !mc.mc_rready;
                h_id = mc.mc_rid; h_data = mc.mc_rdata; h_resp = mc.mc_rresp; h_last = mc.mc_rlast;
                if (mc.mc_bvalid && mc.mc_bready) begin
                    if (bq.size() == 0) tmo("b_unexpected");
                    else begin
                        be = bq.pop_front();
                        chk("bid", 128'(mc.mc_bid), 128'(be.id));
                        chk("bresp", 128'(mc.mc_bresp), 128'(be.resp));
                    end
                    b_seen++;
                end
                if (mc.mc_rvalid && mc.mc_rready) begin
                    if (rq.size() == 0) tmo("r_unexpected");
                    else begin
                        re = rq.pop_front();
                        chk("rid", 128'(mc.mc_rid), 128'(re.id));
                        chk("rresp", 128'(mc.mc_rresp), 128'(re.resp));
                        chk("rlast", 128'(mc.mc_rlast), 128'(re.last));
                        if (re.chk) chk("rdata", mc.mc_rdata, re.data);
                    end
                    r_seen++;
                end
            end
        end
    end

    // Model: apply a write burst and queue its expected B response
    task automatic push_write(input logic [5:0] id, input logic [31:0] addr, input int len, input int bad);
        int unsigned w;
        logic err;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wlst[i] = (i == len);
            if (i == bad) wlst[i] = !wlst[i];
            if (wlst[i] != (i == len)) err = 1'b1;
            w = (addr >> 4) + i;
            if (w < DEPTH) begin
                for (int b = 0; b < 16; b++)
                    if (wstb[i][b]) mdl[w][b*8 +: 8] = wdat[i][b*8 +: 8];
                if (wstb[i] == 16'hFFFF) known[w] = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    endtask

    // Model: queue the expected beats of a read burst
    task automatic push_read(input logic [5:0] id, input logic [31:0] addr, input int len);
        int unsigned w;
        for (int i = 0; i <= len; i++) begin
            w = (addr >> 4) + i;
            if (w < DEPTH) rq.push_back('{id: id, data: mdl[w], resp: 2'b00, last: (i == len), chk: known[w]});
            else           rq.push_back('{id: id, data: '0, resp: 2'b10, last: (i == len), chk: 1'b1});
        end
    endtask

    task automatic wait_rdy(input int which, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if ((which == 0 && mc.mc_awready) || (which == 1 && mc.mc_arready) ||
                (which == 2 && mc.mc_wready)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic aw_go(input logic [5:0] id, input logic [31:0] addr, input int len);
        bit ok;
        mc.mc_awid = id; mc.mc_awaddr = addr; mc.mc_awlen = 8'(len); mc.mc_awvalid = 1'b1;
        wait_rdy(0, ok);
        if (!ok) tmo("aw_timeout");
        @(posedge clk); #1;
        mc.mc_awvalid = 1'b0;
    endtask

    task automatic ar_go(input logic [5:0] id, input logic [31:0] addr, input int len);
        bit ok;
        mc.mc_arid = id; mc.mc_araddr = addr; mc.mc_arlen = 8'(len); mc.mc_arvalid = 1'b1;
        wait_rdy(1, ok);
        if (!ok) tmo("ar_timeout");
        @(posedge clk); #1;
        mc.mc_arvalid = 1'b0;
    endtask

    task automatic w_go(input int len);
        bit ok;
        for (int i = 0; i <= len; i++) begin
            mc.mc_wdata = wdat[i]; mc.mc_wstrb = wstb[i]; mc.mc_wlast = wlst[i]; mc.mc_wvalid = 1'b1;
            wait_rdy(2, ok);
            if (!ok) begin tmo("w_timeout"); break; end
            @(posedge clk); #1;
        end
        mc.mc_wvalid = 1'b0; mc.mc_wlast = 1'b0;
    endtask

    task automatic b_wait(input int tgt);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (b_seen >= tgt) begin ok = 1'b1; break; end
        end
        if (!ok) tmo("b_timeout");
        @(posedge clk); #1;
    endtask

    task automatic r_go(input int start, input int len, input int hold_beat, input int hold_cyc, input bit rnd);
        int held;
        bit ok;
        held = 0; ok = 1'b0;
        for (int c = 0; c < (len + 1) * 8 + 60; c++) begin
            if (r_seen >= start + len + 1) begin ok = 1'b1; break; end
            if (r_seen - start == hold_beat && held < hold_cyc) begin
                mc.mc_rready = 1'b0;
                held++;
            end else begin
                mc.mc_rready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(posedge clk); #1;
        end
        mc.mc_rready = 1'b0;
        if (!ok) tmo("r_timeout");
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input int len, input int bad);
        int tgt;
        tgt = b_seen + 1;
        $display("WR id=%0d addr=%h len=%0d bad_last=%0d", id, addr, len, bad);
        push_write(id, addr, len, bad);
        aw_go(id, addr, len);
        w_go(len);
        b_wait(tgt);
        last_wr = 1'b1;
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input int len,
                           input int hold_beat, input int hold_cyc, input bit rnd);
        int start;
        start = r_seen;
        $display("RD id=%0d addr=%h len=%0d", id, addr, len);
        push_read(id, addr, len);
        ar_go(id, addr, len);
        r_go(start, len, hold_beat, hold_cyc, rnd);
        last_wr = 1'b0;
    endtask

    // Raise AW and AR together; the side not served last must win, the other follows
    task automatic arb_pair(input logic [5:0] wid, input logic [31:0] waddr, input int wlen,
                            input logic [5:0] rid, input logic [31:0] raddr, input int rlen);
        logic [1:0] exp_win, act_win;
        int start, tgt;
        bit ok;
        exp_win = last_wr ? 2'b01 : 2'b10;
        act_win = 2'b00;
        $display("ARB wid=%0d waddr=%h rid=%0d raddr=%h", wid, waddr, rid, raddr);
        mc.mc_awid = wid; mc.mc_awaddr = waddr; mc.mc_awlen = 8'(wlen); mc.mc_awvalid = 1'b1;
        mc.mc_arid = rid; mc.mc_araddr = raddr; mc.mc_arlen = 8'(rlen); mc.mc_arvalid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            act_win = {mc.mc_awready, mc.mc_arready};
            if (act_win != 2'b00) break;
        end
        chk("arb_winner", 128'(act_win), 128'(exp_win));
        if (act_win == 2'b00) begin
            mc.mc_awvalid = 1'b0; mc.mc_arvalid = 1'b0;
            @(posedge clk); #1;
        end else if (act_win[1]) begin
            tgt = b_seen + 1;
            push_write(wid, waddr, wlen, -1);
            @(posedge clk); #1;
            mc.mc_awvalid = 1'b0;
            w_go(wlen);
            b_wait(tgt);
            start = r_seen;
            push_read(rid, raddr, rlen);
            wait_rdy(1, ok);
            if (!ok) tmo("arb_ar_timeout");
            @(posedge clk); #1;
            mc.mc_arvalid = 1'b0;
            r_go(start, rlen, -1, 0, 1'b0);
            last_wr = 1'b0;
        end else begin
            start = r_seen;
            push_read(rid, raddr, rlen);
            @(posedge clk); #1;
            mc.mc_arvalid = 1'b0;
            r_go(start, rlen, -1, 0, 1'b0);
            tgt = b_seen + 1;
            push_write(wid, waddr, wlen, -1);
            wait_rdy(0, ok);
            if (!ok) tmo("arb_aw_timeout");
            @(posedge clk); #1;
            mc.mc_awvalid = 1'b0;
            w_go(wlen);
            b_wait(tgt);
            last_wr = 1'b1;
        end
    endtask

    initial begin : stim
        int start;
        bit ok;
        int unsigned word;
        int len;
        mc.mc_awid = '0; mc.mc_awaddr = '0; mc.mc_awlen = '0; mc.mc_awvalid = 1'b0;
        mc.mc_wdata = '0; mc.mc_wstrb = '0; mc.mc_wlast = 1'b0; mc.mc_wvalid = 1'b0;
        mc.mc_bready = 1'b1;
        mc.mc_arid = '0; mc.mc_araddr = '0; mc.mc_arlen = '0; mc.mc_arvalid = 1'b0;
        mc.mc_rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1'b0; end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 128'(mc.mc_awready), 128'(0));
        chk("rst_wready", 128'(mc.mc_wready), 128'(0));
        chk("rst_arready", 128'(mc.mc_arready), 128'(0));
        chk("rst_bvalid", 128'(mc.mc_bvalid), 128'(0));
        chk("rst_bresp_bid", 128'({mc.mc_bresp, mc.mc_bid}), 128'(0));
        chk("rst_rvalid", 128'(mc.mc_rvalid), 128'(0));
        chk("rst_rlast", 128'(mc.mc_rlast), 128'(0));
        chk("rst_rresp_rid", 128'({mc.mc_rresp, mc.mc_rid}), 128'(0));
        chk("rst_rdata", mc.mc_rdata, 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // simultaneous requests right after reset: write first, data 1..4 read back
        for (int i = 0; i < 4; i++) begin wdat[i] = 128'(i + 1); wstb[i] = 16'hFFFF; end
        arb_pair(6'd5, 32'h40, 3, 6'd9, 32'h40, 3);

        // lone write, then simultaneous again: read wins this time
        for (int i = 0; i < 2; i++) begin wdat[i] = {4{$urandom}}; wstb[i] = 16'hFFFF; end
        do_write(6'd1, 32'h100, 1, -1);
        wdat[0] = {4{$urandom}}; wstb[0] = 16'hFFFF;
        arb_pair(6'd2, 32'h200, 0, 6'd3, 32'h40, 3);

        // byte strobes: clear word 0, write low 4 bytes of all-ones
        wdat[0] = '0; wstb[0] = 16'hFFFF;
        do_write(6'd2, 32'h0, 0, -1);
        wdat[0] = '1; wstb[0] = 16'h000F;
        do_write(6'd3, 32'h0, 0, -1);
        do_read(6'd4, 32'h0, 0, -1, 0, 1'b0);

        // backpressure: rready low for 5 cycles on beat 2
        do_read(6'd6, 32'h40, 3, 1, 5, 1'b0);

        // out-of-range write leaves word 0 alone; out-of-range read is zero/SLVERR
        wdat[0] = {4{$urandom}}; wstb[0] = 16'hFFFF;
        do_write(6'd7, 32'h4000, 0, -1);
        do_read(6'd8, 32'h0, 0, -1, 0, 1'b0);
        do_read(6'd8, 32'h4000, 0, -1, 0, 1'b0);

        // early wlast, missing final wlast, burst running off the end
        for (int i = 0; i < 4; i++) begin wdat[i] = {4{$urandom}}; wstb[i] = 16'hFFFF; end
        do_write(6'd9, 32'h80, 3, 1);
        do_read(6'd9, 32'h80, 3, -1, 0, 1'b0);
        for (int i = 0; i < 4; i++) wdat[i] = {4{$urandom}};
        do_write(6'd10, 32'hC0, 3, 3);
        do_write(6'd11, 32'h3FE0, 3, -1);
        do_read(6'd11, 32'h3FE0, 3, -1, 0, 1'b0);

        // random traffic
        for (int t = 0; t < 30; t++) begin
            word = $urandom_range(0, DEPTH + 3);
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wdat[i] = {4{$urandom}};
                    wstb[i] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
                end
                do_write(6'($urandom), word << 4, len, ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1);
            end else begin
                do_read(6'($urandom), word << 4, len, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
            end
        end

        // reset in the middle of an 8-beat read; earlier writes must survive
        for (int i = 0; i < 8; i++) begin wdat[i] = {4{$urandom}}; wstb[i] = 16'hFFFF; end
        do_write(6'd12, 32'h600, 7, -1);
        start = r_seen;
        $display("RD id=13 addr=00000600 len=7 (reset mid-burst)");
        push_read(6'd13, 32'h600, 7);
        ar_go(6'd13, 32'h600, 7);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (r_seen - start >= 1) begin ok = 1'b1; break; end
            mc.mc_rready = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) tmo("rst_mid_r_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", 128'(mc.mc_rvalid), 128'(0));
        chk("async_rst_rlast", 128'(mc.mc_rlast), 128'(0));
        rq.delete();
        mc.mc_rready = 1'b0;
        last_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(6'd14, 32'h600, 7, -1, 0, 1'b0);

        repeat (4) @(posedge clk);
        chk("bq_drained", 128'(bq.size()), 128'(0));
        chk("rq_drained", 128'(rq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
